// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
//
// UART receive stage for the loopback path. Oversamples the asynchronous
// uart_rxd line with the system clock, recovers 8N1 frames (LSB first) and
// presents each good byte together with a one-cycle done strobe that the
// downstream transmitter consumes. A stop bit sampled low is reported as a
// framing error; a start bit that is high again at mid-bit is treated as a
// glitch and dropped without any output pulse.
//
// Optional feature (compile-time macro UART_PARITY_EN):
//   defined   - an even-parity bit follows the data bits (11-bit frame). A
//               parity mismatch pulses uart_parity_err instead of done. A bad
//               stop bit wins over a parity mismatch.
//   undefined - no parity bit; uart_parity_err is tied to 0.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   UART_BPS  baud rate in bit/s
//
// Ports:
//   sys_clk          in   system clock, rising edge
//   sys_rst_n        in   asynchronous active-low reset
//   uart_rxd         in   serial line, idle high, asynchronous to sys_clk
//   uart_rx_data     out  [7:0] last good received byte (held until next good frame)
//   uart_rx_done     out  one-cycle pulse, uart_rx_data valid on and after it
//   uart_frame_err   out  one-cycle pulse, stop bit sampled low
//   uart_rx_busy     out  high from start-edge detect until return to IDLE
//   uart_parity_err  out  one-cycle pulse, parity mismatch (0 without parity)
// -----------------------------------------------------------------------------
module uart_rx_frame #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_rxd,
  output logic [7:0] uart_rx_data,
  output logic       uart_rx_done,
  output logic       uart_frame_err,
  output logic       uart_rx_busy,
  output logic       uart_parity_err
);

  // Clocks per bit and the count at which a bit is sampled (its centre).
  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;
  localparam int CNT_W    = $clog2(BPS_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_CNT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

`ifdef UART_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
    return ((^data) ^ par) == 1'b0;
  endfunction
`endif

  // Input synchronizer and edge-detect history.
  logic              rxd_meta_r;
  logic              rxd_sync_r;
  logic              rxd_prev_r;
  logic              start_edge_s;

  // FSM and datapath state.
  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  baud_cnt_r;
  logic              mid_bit_s;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;

  // Per-cycle control strobes decoded by the FSM.
  logic              cnt_clr_s;
  logic              busy_set_s;
  logic              busy_clr_s;
  logic              idx_clr_s;
  logic              shift_en_s;
  logic              load_s;
  logic              ferr_s;

`ifdef UART_PARITY_EN
  logic              parity_bit_r;
  logic              par_sample_s;
  logic              perr_s;
`endif

  assign start_edge_s = (rxd_sync_r == 1'b0) && (rxd_prev_r == 1'b1);
  assign mid_bit_s    = (baud_cnt_r == CNT_MID);

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and control-strobe decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    busy_set_s  = 1'b0;
    busy_clr_s  = 1'b0;
    idx_clr_s   = 1'b0;
    shift_en_s  = 1'b0;
    load_s      = 1'b0;
    ferr_s      = 1'b0;
`ifdef UART_PARITY_EN
    par_sample_s = 1'b0;
    perr_s       = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          state_nxt_s = START;
          cnt_clr_s   = 1'b1;
          busy_set_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (mid_bit_s) begin
          if (rxd_sync_r == 1'b0) begin
            state_nxt_s = DATA;
            idx_clr_s   = 1'b1;
          end else begin
            // Line already back high at mid start bit: glitch, drop silently.
            state_nxt_s = IDLE;
            busy_clr_s  = 1'b1;
          end
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (mid_bit_s) begin
          shift_en_s = 1'b1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt_s = PARITY;
`else
            state_nxt_s = STOP;
`endif
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (mid_bit_s) begin
          par_sample_s = 1'b1;
          state_nxt_s  = STOP;
        end else begin
          state_nxt_s = PARITY;
        end
      end
`endif
      STOP: begin
        if (mid_bit_s) begin
          // Leave at the stop-bit centre so a back-to-back start edge half a
          // bit later is still caught in IDLE.
          state_nxt_s = IDLE;
          busy_clr_s  = 1'b1;
          if (rxd_sync_r == 1'b1) begin
`ifdef UART_PARITY_EN
            if (even_parity_ok(shift_r, parity_bit_r)) begin
              load_s = 1'b1;
            end else begin
              perr_s = 1'b1;
            end
`else
            load_s = 1'b1;
`endif
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        busy_clr_s  = 1'b1;
      end
    endcase
  end

  // Baud counter: free-runs 0..BPS_CNT-1 while a frame is in progress.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt_r <= '0;
    end else if (cnt_clr_s || (state_r == IDLE)) begin
      baud_cnt_r <= '0;
    end else if (baud_cnt_r == CNT_LAST) begin
      baud_cnt_r <= '0;
    end else begin
      baud_cnt_r <= baud_cnt_r + CNT_W'(1);
    end
  end

  // Data bit index and LSB-first assembly of the received byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else if (idx_clr_s) begin
      bit_idx_r <= 3'd0;
    end else if (shift_en_s) begin
      shift_r[bit_idx_r] <= rxd_sync_r;
      bit_idx_r          <= bit_idx_r + 3'd1;
    end else begin
      bit_idx_r <= bit_idx_r;
    end
  end

`ifdef UART_PARITY_EN
  // Captures the received parity bit at its mid-bit sample.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      parity_bit_r <= 1'b0;
    end else if (par_sample_s) begin
      parity_bit_r <= rxd_sync_r;
    end else begin
      parity_bit_r <= parity_bit_r;
    end
  end

  // Registered parity-error strobe.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart_parity_err <= 1'b0;
    end else begin
      uart_parity_err <= perr_s;
    end
  end
`else
  assign uart_parity_err = 1'b0;
`endif

  // Registered result outputs: data word, strobes and busy flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart_rx_data   <= 8'h00;
      uart_rx_done   <= 1'b0;
      uart_frame_err <= 1'b0;
      uart_rx_busy   <= 1'b0;
    end else begin
      uart_rx_done   <= load_s;
      uart_frame_err <= ferr_s;
      if (load_s) begin
        uart_rx_data <= shift_r;
      end else begin
        uart_rx_data <= uart_rx_data;
      end
      if (busy_set_s) begin
        uart_rx_busy <= 1'b1;
      end else if (busy_clr_s) begin
        uart_rx_busy <= 1'b0;
      end else begin
        uart_rx_busy <= uart_rx_busy;
      end
    end
  end

endmodule
